// File: rtl/pe_dot_sequencer.sv
// pe_dot_sequencer
// Drive side of a PE MAC interface. Streams IFM/weight operand pairs from two
// synchronous-read buffers into one PE and frames each dot product with
// pe_restart/pe_finish. Each final PE sum is captured and handed out on a
// valid/ready result port, one result per filter.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   start, cfg_len, cfg_num   job start pulse and job shape (latched on start)
//   busy, done                job in progress, 1-cycle completion pulse
//   ifm_rd_addr/ifm_rd_data   IFM buffer read port (data one cycle after address)
//   w_rd_addr/w_rd_data       weight buffer read port (filter-major layout)
//   pe_ifm, pe_weight         operands to the PE (zero on bubble cycles)
//   pe_restart, pe_finish     first / last element of a dot product
//   pe_ofm, pe_valid          PE result and its valid strobe
//   res_data, res_idx,
//   res_last, res_valid,
//   res_ready                 result stream
//
// state | meaning
// IDLE  | waiting for start; zero-sized jobs complete here immediately
// RUN   | issuing operand reads, one element per cycle unless stalled
// DRAIN | all elements issued; waiting for the last result to be accepted
module pe_dot_sequencer #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8,
   parameter int NUM_W  = 8,
   parameter int IA_W   = 8,
   parameter int WA_W   = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [NUM_W-1:0]  cfg_num,
   output logic              busy,
   output logic              done,
   output logic [IA_W-1:0]   ifm_rd_addr,
   input  logic [DATA_W-1:0] ifm_rd_data,
   output logic [WA_W-1:0]   w_rd_addr,
   input  logic [DATA_W-1:0] w_rd_data,
   output logic [DATA_W-1:0] pe_ifm,
   output logic [DATA_W-1:0] pe_weight,
   output logic              pe_restart,
   output logic              pe_finish,
   input  logic [DATA_W-1:0] pe_ofm,
   input  logic              pe_valid,
   output logic [DATA_W-1:0] res_data,
   output logic [NUM_W-1:0]  res_idx,
   output logic              res_last,
   output logic              res_valid,
   input  logic              res_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   logic [LEN_W-1:0]   len_q;
   logic [NUM_W-1:0]   num_q;
   logic [LEN_W-1:0]   k;
   logic [WA_W-1:0]    w_ptr;
   logic [NUM_W-1:0]   f_iss;
   logic [NUM_W-1:0]   f_res;
   logic               s1_valid;
   logic               s1_first;
   logic               s1_last;

   logic               k_last;
   logic               f_iss_last;
   logic               res_slot_free;
   logic               can_issue;

   assign k_last        = (k == len_q - LEN_W'(1));
   assign f_iss_last    = (f_iss == num_q - NUM_W'(1));
   assign res_slot_free = !res_valid || res_ready;

   // Only the closing element of a dot product may stall. Holding it back
   // until no finish/valid is in flight and the result slot can drain means
   // a new PE result never arrives while the previous one is still unread.
   assign can_issue = !k_last || (!s1_last && !pe_valid && res_slot_free);

   assign ifm_rd_addr = IA_W'(k);
   assign w_rd_addr   = w_ptr;

   // Stage 1 lines up with the buffer read latency; bubbles present zeros
   // so the PE accumulator holds its value.
   assign pe_ifm     = s1_valid ? ifm_rd_data : '0;
   assign pe_weight  = s1_valid ? w_rd_data   : '0;
   assign pe_restart = s1_first;
   assign pe_finish  = s1_last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         len_q     <= '0;
         num_q     <= '0;
         k         <= '0;
         w_ptr     <= '0;
         f_iss     <= '0;
         f_res     <= '0;
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         res_data  <= '0;
         res_idx   <= '0;
         res_last  <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         done     <= 1'b0;
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;

         if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
         end

         if (pe_valid) begin
            res_valid <= 1'b1;
            res_data  <= pe_ofm;
            res_idx   <= f_res;
            res_last  <= (f_res == num_q - NUM_W'(1));
            f_res     <= f_res + NUM_W'(1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_len == '0 || cfg_num == '0) begin
                     done <= 1'b1;
                  end else begin
                     len_q <= cfg_len;
                     num_q <= cfg_num;
                     k     <= '0;
                     w_ptr <= '0;
                     f_iss <= '0;
                     f_res <= '0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end

            RUN: begin
               if (can_issue) begin
                  s1_valid <= 1'b1;
                  s1_first <= (k == '0);
                  s1_last  <= k_last;
                  // Counters park on the final element so the read
                  // addresses stay put while the job drains.
                  if (k_last && f_iss_last) begin
                     state <= DRAIN;
                  end else begin
                     w_ptr <= w_ptr + WA_W'(1);
                     if (k_last) begin
                        k     <= '0;
                        f_iss <= f_iss + NUM_W'(1);
                     end else begin
                        k <= k + LEN_W'(1);
                     end
                  end
               end
            end

            DRAIN: begin
               if (res_valid && res_ready && res_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
module tb_pe_dot_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  cfg_len = '0;
   logic [7:0]  cfg_num = '0;
   logic        busy, done;
   logic [7:0]  ifm_rd_addr;
   logic [7:0]  ifm_rd_data;
   logic [15:0] w_rd_addr;
   logic [7:0]  w_rd_data;
   logic [7:0]  pe_ifm, pe_weight;
   logic        pe_restart, pe_finish;
   logic [7:0]  pe_ofm;
   logic        pe_valid;
   logic [7:0]  res_data;
   logic [7:0]  res_idx;
   logic        res_last, res_valid;
   logic        res_ready = 1'b1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pe_dot_sequencer #(.DATA_W(8), .LEN_W(8), .NUM_W(8), .IA_W(8), .WA_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .cfg_len(cfg_len), .cfg_num(cfg_num),
      .busy(busy), .done(done),
      .ifm_rd_addr(ifm_rd_addr), .ifm_rd_data(ifm_rd_data),
      .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
      .pe_ifm(pe_ifm), .pe_weight(pe_weight), .pe_restart(pe_restart), .pe_finish(pe_finish),
      .pe_ofm(pe_ofm), .pe_valid(pe_valid),
      .res_data(res_data), .res_idx(res_idx), .res_last(res_last),
      .res_valid(res_valid), .res_ready(res_ready)
   );

   // Operand buffers: synchronous read, data one cycle after the address.
   logic [7:0] ifm_mem [256];
   logic [7:0] w_mem [65536];
   always @(posedge clk) begin
      ifm_rd_data <= ifm_mem[ifm_rd_addr];
      w_rd_data   <= w_mem[w_rd_addr];
   end

   // PE: accumulate products mod 256, restart on first element, result valid after finish.
   logic [7:0] pe_acc;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pe_acc   <= '0;
         pe_valid <= 1'b0;
      end else begin
         pe_valid <= pe_finish;
         if (pe_restart) pe_acc <= pe_ifm * pe_weight;
         else            pe_acc <= pe_acc + pe_ifm * pe_weight;
      end
   end
   assign pe_ofm = pe_acc;

   logic [7:0] exp_res [256];

   task automatic chk_eq(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk_eq({tag, "_busy"}, busy, 0);
      chk_eq({tag, "_done"}, done, 0);
      chk_eq({tag, "_res_valid"}, res_valid, 0);
      chk_eq({tag, "_res_last"}, res_last, 0);
      chk_eq({tag, "_res_data"}, res_data, 0);
      chk_eq({tag, "_res_idx"}, res_idx, 0);
      chk_eq({tag, "_ifm_addr"}, ifm_rd_addr, 0);
      chk_eq({tag, "_w_addr"}, w_rd_addr, 0);
      chk_eq({tag, "_pe_ifm"}, pe_ifm, 0);
      chk_eq({tag, "_pe_weight"}, pe_weight, 0);
      chk_eq({tag, "_pe_restart"}, pe_restart, 0);
      chk_eq({tag, "_pe_finish"}, pe_finish, 0);
   endtask

   // Reference: each result is the plain dot product of the IFM vector with
   // the filter's slice of the filter-major weight array, reduced mod 256.
   task automatic model_job(input int len, input int num);
      for (int f = 0; f < num; f++) begin
         int s;
         s = 0;
         for (int k = 0; k < len; k++) s = s + ifm_mem[k] * w_mem[f * len + k];
         exp_res[f] = 8'(s);
      end
   endtask

   // Runs one job; called at a negedge. bp holds res_ready low for bp cycles
   // after the first result appears; rnd randomizes res_ready otherwise and
   // pokes start mid-job (must be ignored).
   task automatic run_job(input int len, input int num, input int bp, input bit rnd);
      int cyc, acc_n, rs_n, fin_n, both_n, hold;
      bit last_acc, first_seen, prev_hold, done_ok;
      logic [7:0] prev_data, prev_idx;
      cyc = 0; acc_n = 0; rs_n = 0; fin_n = 0; both_n = 0; hold = 0;
      last_acc = 0; first_seen = 0; prev_hold = 0; done_ok = 0;
      prev_data = '0; prev_idx = '0;
      cfg_len = 8'(len); cfg_num = 8'(num); start = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; cfg_len = 8'($urandom); cfg_num = 8'($urandom);
      chk_eq("busy_after_start", busy, 1);
      while (cyc < 3000 && !done_ok) begin
         if (pe_restart) rs_n++;
         if (pe_finish) begin
            fin_n++;
            chk_eq("finish_with_full_slot", res_valid, 0);
         end
         if (pe_restart && pe_finish) both_n++;
         if (last_acc) begin
            chk_eq("done_after_last", done, 1);
            chk_eq("busy_after_last", busy, 0);
            done_ok = 1;
         end else begin
            chk_eq("done_early", done, 0);
            if (prev_hold) begin
               chk_eq("res_valid_held", res_valid, 1);
               chk_eq("res_data_stable", res_data, prev_data);
               chk_eq("res_idx_stable", res_idx, prev_idx);
            end
            if (res_valid && !first_seen) begin
               first_seen = 1;
               hold = bp;
            end
            if (hold > 0) begin
               res_ready = 1'b0;
               hold--;
            end else begin
               res_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            start = rnd && (cyc == 2);
            if (pe_valid) chk_eq("pe_valid_while_full", res_valid && !res_ready, 0);
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            prev_idx  = res_idx;
            if (res_valid && res_ready) begin
               chk_eq("res_data", res_data, exp_res[acc_n]);
               chk_eq("res_idx", res_idx, acc_n);
               chk_eq("res_last", res_last, acc_n == num - 1);
               if (acc_n == num - 1) last_acc = 1;
               acc_n++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      res_ready = 1'b1;
      chk_eq("job_completed", done_ok, 1);
      chk_eq("result_count", acc_n, num);
      chk_eq("restart_count", rs_n, num);
      chk_eq("finish_count", fin_n, num);
      chk_eq("restart_finish_together", both_n, (len == 1) ? num : 0);
   endtask

   typedef struct packed {
      logic [7:0]       len;
      logic [7:0]       num;
      logic [7:0]       bp;
      logic [3:0][7:0]  ifm;
      logic [7:0][7:0]  w;
      logic [3:0][7:0]  exp;
   } vec_t;

   vec_t vt [4];

   task automatic load_vec(input vec_t v);
      for (int k = 0; k < int'(v.len); k++) ifm_mem[k] = v.ifm[k];
      for (int j = 0; j < int'(v.len) * int'(v.num); j++) w_mem[j] = v.w[j];
      for (int f = 0; f < int'(v.num); f++) exp_res[f] = v.exp[f];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  a_ifm;
      logic [15:0] a_w;
      int len, num;

      // {element N-1 .. element 0} in each packed field
      vt[0] = '{len: 8'd3, num: 8'd2, bp: 8'd0,
                ifm: {8'd0, 8'd3, 8'd2, 8'd1},
                w:   {8'd0, 8'd0, 8'd1, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1},
                exp: {8'd0, 8'd0, 8'd5, 8'd6}};
      vt[1] = '{len: 8'd2, num: 8'd1, bp: 8'd0,
                ifm: {8'd0, 8'd0, 8'd20, 8'd20},
                w:   {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd10},
                exp: {8'd0, 8'd0, 8'd0, 8'd144}};
      vt[2] = '{len: 8'd3, num: 8'd2, bp: 8'd10,
                ifm: {8'd0, 8'd3, 8'd2, 8'd1},
                w:   {8'd0, 8'd0, 8'd1, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1},
                exp: {8'd0, 8'd0, 8'd5, 8'd6}};
      vt[3] = '{len: 8'd1, num: 8'd4, bp: 8'd0,
                ifm: {8'd0, 8'd0, 8'd0, 8'd3},
                w:   {8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1},
                exp: {8'd12, 8'd9, 8'd6, 8'd3}};

      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Directed jobs: basic, wrap, backpressure, len==1
      for (int i = 0; i < 4; i++) begin
         load_vec(vt[i]);
         run_job(int'(vt[i].len), int'(vt[i].num), int'(vt[i].bp), 1'b0);
         repeat (2) @(negedge clk);
      end

      // Reset mid-RUN after two elements issued, then rerun the basic job
      load_vec(vt[0]);
      cfg_len = 8'd3; cfg_num = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk_eq("midrun_ifm_addr", ifm_rd_addr, 2);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      load_vec(vt[0]);
      run_job(3, 2, 0, 1'b0);
      repeat (2) @(negedge clk);

      // Zero-sized jobs: cfg_num==0 then cfg_len==0
      for (int z = 0; z < 2; z++) begin
         a_ifm = ifm_rd_addr;
         a_w   = w_rd_addr;
         cfg_len = (z == 0) ? 8'd3 : 8'd0;
         cfg_num = (z == 0) ? 8'd0 : 8'd2;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk_eq("zero_done", done, 1);
         chk_eq("zero_busy", busy, 0);
         repeat (4) begin
            @(negedge clk);
            chk_eq("zero_done_once", done, 0);
            chk_eq("zero_busy_low", busy, 0);
            chk_eq("zero_res_valid", res_valid, 0);
            chk_eq("zero_ifm_addr", ifm_rd_addr, a_ifm);
            chk_eq("zero_w_addr", w_rd_addr, a_w);
         end
      end

      // Random jobs against the reference model
      for (int j = 0; j < 25; j++) begin
         len = $urandom_range(1, 8);
         num = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) ifm_mem[k] = 8'($urandom);
         for (int i = 0; i < len * num; i++) w_mem[i] = 8'($urandom);
         model_job(len, num);
         run_job(len, num, (j % 5 == 0) ? $urandom_range(1, 8) : 0, 1'b1);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
